// File: rtl/rks_tape_player.sv
// Cassette-side tape transmitter: streams pilot, sync byte and payload from
// memory as a Manchester-encoded level on tape_out for the PPI tape input.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_IDLE  | waiting for start; tape_out low
//  S_PILOT | sending PILOT_LEN bytes of 8'h00
//  S_SYNC  | sending SYNC_BYTE once; fetch of payload byte 0 in flight
//  S_DATA  | sending payload bytes 0..length-1; next byte prefetched
//  S_TAIL  | holding tape_out low for one bit time, then done
module rks_tape_player #(
    parameter int         HALF_PERIOD = 320,
    parameter int         PILOT_LEN   = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'hE6,
    parameter int         ADDR_W      = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_tape,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] length,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              rd_ack,
    output logic              tape_out,
    output logic              busy,
    output logic              done
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int PW = (PILOT_LEN > 1) ? $clog2(PILOT_LEN) : 1;
    localparam logic [HW-1:0] HP_TC    = HW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] PILOT_TC = PW'(PILOT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PILOT,
        S_SYNC,
        S_DATA,
        S_TAIL
    } state_t;

    state_t            state;
    logic [HW-1:0]     hcnt;
    logic              second_half;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [PW-1:0]     pilot_cnt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] data_idx;
    logic [7:0]        buf_q;
    logic              buf_valid;
    logic              stall;

    logic [ADDR_W-1:0] nxt_idx;
    logic [ADDR_W-1:0] nxt_fetch;
    logic              last_byte;
    logic [2:0]        bit_dn;

    // Index of the payload byte that follows the current one, the address to
    // prefetch after it, and whether the current byte is the last to send.
    always_comb begin
        nxt_idx   = (state == S_SYNC) ? '0 : data_idx + ADDR_W'(1);
        nxt_fetch = nxt_idx + ADDR_W'(1);
        last_byte = (state == S_SYNC) ? (len_q == '0)
                                      : (data_idx == len_q - ADDR_W'(1));
        bit_dn    = bit_idx - 3'd1;
    end

    // Sequencer, bit timer, byte shifter and fetch handshake.
    always_ff @(posedge clk_sys) begin
        done <= 1'b0;
        if (reset) begin
            state       <= S_IDLE;
            tape_out    <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            hcnt        <= '0;
            second_half <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            pilot_cnt   <= '0;
            len_q       <= '0;
            data_idx    <= '0;
            buf_q       <= '0;
            buf_valid   <= 1'b0;
            stall       <= 1'b0;
        end else if (stop && state != S_IDLE) begin
            // Abort: any fetch in flight is dropped and no done pulse is given.
            state     <= S_IDLE;
            tape_out  <= 1'b0;
            rd_req    <= 1'b0;
            busy      <= 1'b0;
            buf_valid <= 1'b0;
            stall     <= 1'b0;
        end else begin
            if (rd_req && rd_ack) begin
                buf_q     <= rd_data;
                buf_valid <= 1'b1;
                rd_req    <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        len_q       <= length;
                        busy        <= 1'b1;
                        state       <= S_PILOT;
                        pilot_cnt   <= '0;
                        buf_valid   <= 1'b0;
                        stall       <= 1'b0;
                        shreg       <= 8'h00;
                        bit_idx     <= 3'd7;
                        second_half <= 1'b0;
                        hcnt        <= HP_TC;
                        tape_out    <= 1'b1;
                    end
                end

                S_PILOT, S_SYNC, S_DATA: begin
                    if (stall) begin
                        // Level and timer stay frozen until the byte arrives;
                        // it then starts with a fresh half-period.
                        if (buf_valid) begin
                            stall       <= 1'b0;
                            state       <= S_DATA;
                            data_idx    <= nxt_idx;
                            buf_valid   <= 1'b0;
                            shreg       <= buf_q;
                            bit_idx     <= 3'd7;
                            second_half <= 1'b0;
                            hcnt        <= HP_TC;
                            tape_out    <= ~buf_q[7];
                            if (nxt_fetch < len_q) begin
                                rd_req  <= 1'b1;
                                rd_addr <= nxt_fetch;
                            end
                        end
                    end else if (ce_tape) begin
                        if (hcnt != '0) begin
                            hcnt <= hcnt - HW'(1);
                        end else if (!second_half) begin
                            second_half <= 1'b1;
                            hcnt        <= HP_TC;
                            tape_out    <= shreg[bit_idx];
                        end else if (bit_idx != 3'd0) begin
                            bit_idx     <= bit_dn;
                            second_half <= 1'b0;
                            hcnt        <= HP_TC;
                            tape_out    <= ~shreg[bit_dn];
                        end else if (state == S_PILOT) begin
                            bit_idx     <= 3'd7;
                            second_half <= 1'b0;
                            hcnt        <= HP_TC;
                            if (pilot_cnt == PILOT_TC) begin
                                pilot_cnt <= '0;
                                state     <= S_SYNC;
                                shreg     <= SYNC_BYTE;
                                tape_out  <= ~SYNC_BYTE[7];
                                if (len_q != '0) begin
                                    rd_req  <= 1'b1;
                                    rd_addr <= '0;
                                end
                            end else begin
                                pilot_cnt <= pilot_cnt + PW'(1);
                                shreg     <= 8'h00;
                                tape_out  <= 1'b1;
                            end
                        end else if (last_byte) begin
                            state       <= S_TAIL;
                            tape_out    <= 1'b0;
                            second_half <= 1'b0;
                            hcnt        <= HP_TC;
                        end else if (buf_valid) begin
                            state       <= S_DATA;
                            data_idx    <= nxt_idx;
                            buf_valid   <= 1'b0;
                            shreg       <= buf_q;
                            bit_idx     <= 3'd7;
                            second_half <= 1'b0;
                            hcnt        <= HP_TC;
                            tape_out    <= ~buf_q[7];
                            if (nxt_fetch < len_q) begin
                                rd_req  <= 1'b1;
                                rd_addr <= nxt_fetch;
                            end
                        end else begin
                            stall <= 1'b1;
                        end
                    end
                end

                S_TAIL: begin
                    if (ce_tape) begin
                        if (hcnt != '0) begin
                            hcnt <= hcnt - HW'(1);
                        end else if (!second_half) begin
                            second_half <= 1'b1;
                            hcnt        <= HP_TC;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tape_out <= 1'b0;
                    rd_req   <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
